// File: rtl/ternary_fetch_unit.sv
// ternary_fetch_unit: instruction fetch sequencer between the ternary PC, instruction memory and decode.
// Ports: clock/reset_n (sync, active-low); pc_addr in; mem_addr/mem_read_enable out, mem_ready/mem_data in;
// instr_out/instr_valid out, instr_ready in; branch_enable/branch_offset/flush in; pc_update_enable/pc_value out.
// Trits are 2 bits: `TRIT_M1 = -1, `TRIT_Z = 0, `TRIT_P1 = +1.
`ifndef TRIT_M1
`define TRIT_M1 2'b10
`endif
`ifndef TRIT_Z
`define TRIT_Z 2'b00
`endif
`ifndef TRIT_P1
`define TRIT_P1 2'b01
`endif

module ternary_fetch_unit #(
    parameter int WORD_SIZE     = 9,
    parameter int MEM_ADDR_SIZE = 6
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [2*MEM_ADDR_SIZE-1:0] pc_addr,
    output logic [2*MEM_ADDR_SIZE-1:0] mem_addr,
    output logic                       mem_read_enable,
    input  logic                       mem_ready,
    input  logic [2*WORD_SIZE-1:0]     mem_data,
    output logic [2*WORD_SIZE-1:0]     instr_out,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    input  logic                       branch_enable,
    input  logic [2*WORD_SIZE-1:0]     branch_offset,
    input  logic                       flush,
    output logic                       pc_update_enable,
    output logic [2*WORD_SIZE-1:0]     pc_value
);
    localparam logic [1:0] ISSUE   = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    localparam logic [1:0] ADVANCE = 2'd3;
    localparam logic [2*WORD_SIZE-1:0] STEP = {{(WORD_SIZE-1){`TRIT_Z}}, `TRIT_P1};
    localparam logic [2*WORD_SIZE-1:0] ZERO = {WORD_SIZE{`TRIT_Z}};
    logic [1:0] state;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= ISSUE;
            mem_read_enable  <= 1'b0;
            instr_valid      <= 1'b0;
            pc_update_enable <= 1'b0;
            mem_addr         <= {MEM_ADDR_SIZE{`TRIT_M1}};
            instr_out        <= ZERO;
            pc_value         <= ZERO;
        end else if (flush && state != ADVANCE) begin
            // the PC pulse already in flight in ADVANCE must complete, so flush stops short of it
            state            <= ISSUE;
            mem_read_enable  <= 1'b0;
            instr_valid      <= 1'b0;
            pc_update_enable <= 1'b0;
        end else begin
            case (state)
                ISSUE: begin
                    mem_addr        <= pc_addr;
                    mem_read_enable <= 1'b1;
                    state           <= WAIT;
                end
                WAIT: if (mem_ready) begin
                    instr_out       <= mem_data;
                    instr_valid     <= 1'b1;
                    mem_read_enable <= 1'b0;
                    state           <= HOLD;
                end
                HOLD: if (instr_ready) begin
                    instr_valid      <= 1'b0;
                    pc_update_enable <= 1'b1;
                    pc_value         <= branch_enable ? branch_offset : STEP;
                    state            <= ADVANCE;
                end
                default: begin
                    pc_update_enable <= 1'b0;
                    pc_value         <= ZERO;
                    state            <= ISSUE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ternary_fetch_unit.sv
// tb_ternary_fetch_unit: directed bench with an integer PC model and a per-cycle compare process.
`ifndef TRIT_M1
`define TRIT_M1 2'b10
`endif
`ifndef TRIT_Z
`define TRIT_Z 2'b00
`endif
`ifndef TRIT_P1
`define TRIT_P1 2'b01
`endif

module tb_ternary_fetch_unit;
    localparam int W = 9;
    localparam int A = 6;
    localparam logic [17:0] STEP = 18'h00001;
    localparam logic [17:0] OFF_M4 = 18'h0000A;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, mem_read_enable, mem_ready, instr_valid, instr_ready;
    logic        branch_enable, flush, pc_update_enable;
    logic [11:0] pc_addr, mem_addr;
    logic [17:0] mem_data, instr_out, branch_offset, pc_value;

    ternary_fetch_unit #(.WORD_SIZE(W), .MEM_ADDR_SIZE(A)) dut (
        .clock(clock), .reset_n(reset_n), .pc_addr(pc_addr), .mem_addr(mem_addr),
        .mem_read_enable(mem_read_enable), .mem_ready(mem_ready), .mem_data(mem_data),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_enable(branch_enable), .branch_offset(branch_offset), .flush(flush),
        .pc_update_enable(pc_update_enable), .pc_value(pc_value)
    );

    int tests = 0;
    int fails = 0;

    function automatic int wrap(input int v, input int n);
        int m = 1;
        for (int i = 0; i < n; i++) m *= 3;
        v = ((v % m) + m) % m;
        if (v > (m - 1) / 2) v -= m;
        return v;
    endfunction

    function automatic int to_int(input logic [17:0] t, input int n);
        int v = 0;
        for (int i = n - 1; i >= 0; i--)
            v = v * 3 + (t[2*i+:2] == `TRIT_P1 ? 1 : t[2*i+:2] == `TRIT_M1 ? -1 : 0);
        return v;
    endfunction

    function automatic logic [17:0] from_int(input int v, input int n);
        logic [17:0] t = '0;
        int r;
        v = wrap(v, n);
        for (int i = 0; i < n; i++) begin
            r = ((v % 3) + 3) % 3;
            if (r == 2) r = -1;
            t[2*i+:2] = r == 1 ? `TRIT_P1 : r == -1 ? `TRIT_M1 : `TRIT_Z;
            v = (v - r) / 3;
        end
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PC plant: loads on pc_load, otherwise adds pc_value on the pulse, truncated to A trits
    int          pc_int = 0;
    logic        pc_load = 1'b0;
    int          pc_load_val = 0;
    logic [17:0] pc_full;
    assign pc_full = from_int(pc_int, A);
    assign pc_addr = pc_full[11:0];
    always @(posedge clock)
        if (pc_load) pc_int <= pc_load_val;
        else if (pc_update_enable) pc_int <= wrap(pc_int + to_int(pc_value, W), A);

    int          exp_pc = 0;
    logic [17:0] exp_pcv = STEP;
    logic        rst_edge = 1'b0;
    always @(posedge clock) rst_edge <= !reset_n;

    logic        mre_prev, pcu_prev, valid_prev;
    logic [11:0] addr_prev;
    logic [17:0] instr_prev, exp_addr;
    initial forever begin
        @(negedge clock);
        exp_addr = from_int(exp_pc, A);
        if (rst_edge) begin
            check("rst_rd", mem_read_enable, 0);
            check("rst_valid", instr_valid, 0);
            check("rst_pcu", pc_update_enable, 0);
            check("rst_addr", mem_addr, 12'hAAA);
            check("rst_instr", instr_out, 0);
            check("rst_pcv", pc_value, 0);
        end else begin
            if (pc_update_enable) begin
                check("pulse_single", pcu_prev, 0);
                check("pulse_vs_valid", instr_valid, 0);
                check("pulse_value", pc_value, exp_pcv);
            end
            if (mem_read_enable && !mre_prev) check("issue_addr_model", mem_addr, exp_addr[11:0]);
            if (mem_read_enable && mre_prev) check("addr_stable", mem_addr, addr_prev);
            if (instr_valid && valid_prev) check("instr_stable", instr_out, instr_prev);
        end
        mre_prev = mem_read_enable;
        pcu_prev = pc_update_enable;
        valid_prev = instr_valid;
        addr_prev = mem_addr;
        instr_prev = instr_out;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // one full fetch starting with the DUT in ISSUE: md cycles of memory delay, id cycles of decode delay
    task automatic fetch(input int md, input logic [17:0] data, input int id, input logic be, input logic [17:0] bo);
        logic [17:0] ea;
        ea = from_int(exp_pc, A);
        tick();
        check("issue_rd", mem_read_enable, 1);
        check("issue_addr", mem_addr, ea[11:0]);
        repeat (md) begin
            branch_enable = 1'($urandom);
            tick();
            check("wait_rd", mem_read_enable, 1);
            check("wait_valid", instr_valid, 0);
        end
        mem_ready = 1'b1;
        mem_data = data;
        tick();
        mem_ready = 1'b0;
        mem_data = 18'($urandom);
        check("hold_valid", instr_valid, 1);
        check("hold_instr", instr_out, data);
        check("hold_rd", mem_read_enable, 0);
        repeat (id) begin
            branch_enable = 1'b1;
            branch_offset = 18'($urandom);
            tick();
            check("hold_wait_valid", instr_valid, 1);
            check("hold_wait_pcu", pc_update_enable, 0);
        end
        instr_ready = 1'b1;
        branch_enable = be;
        branch_offset = bo;
        exp_pcv = be ? bo : STEP;
        tick();
        instr_ready = 1'b0;
        branch_enable = 1'b0;
        branch_offset = 18'($urandom);
        check("accept_valid", instr_valid, 0);
        check("accept_pcu", pc_update_enable, 1);
        check("accept_pcv", pc_value, exp_pcv);
        tick();
        check("adv_pcu", pc_update_enable, 0);
        check("adv_pcv", pc_value, 0);
        check("adv_rd", mem_read_enable, 0);
        exp_pc = wrap(exp_pc + (be ? to_int(bo, W) : 1), A);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        mem_ready = 1'b0;
        instr_ready = 1'b0;
        branch_enable = 1'b0;
        branch_offset = '0;
        mem_data = '0;
        pc_load = 1'b1;
        pc_load_val = -364;
        exp_pc = -364;
        repeat (3) tick();
        pc_load = 1'b0;
        check("model_all_m1", to_int(18'h00AAA, A), -364);
        check("model_m4", from_int(-4, W), OFF_M4);
        check("model_step", from_int(1, W), STEP);
        check("model_wrap", wrap(-370, A), 359);
        check("rst_addr_lit", mem_addr, 12'hAAA);
        check("rst_rd_lit", mem_read_enable, 0);
        reset_n = 1'b1;
        tick();
        check("release_rd", mem_read_enable, 1);
        check("release_addr", mem_addr, 12'hAAA);
        // fetch is the full ISSUE..ADVANCE sequence, so restart the fetch from ISSUE via a reset pulse
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        fetch(0, 18'h09A52, 0, 1'b0, '0);
        fetch(5, 18'h21468, 3, 1'b0, '0);
        fetch(1, 18'h15A01, 0, 1'b1, OFF_M4);
        fetch(0, 18'h2A915, 0, 1'b1, OFF_M4);
        check("wrap_pc", pc_int, 359);
        fetch(0, 18'h05546, 1, 1'b1, '0);
        fetch(2, 18'h11111, 0, 1'b1, from_int(13, W));
        // flush in WAIT with mem_ready; PC is moved elsewhere meanwhile
        tick();
        check("fl_wait_rd", mem_read_enable, 1);
        mem_ready = 1'b1;
        flush = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 100;
        tick();
        mem_ready = 1'b0;
        flush = 1'b0;
        pc_load = 1'b0;
        exp_pc = 100;
        check("fl_wait_valid", instr_valid, 0);
        check("fl_wait_rd0", mem_read_enable, 0);
        check("fl_wait_pcu", pc_update_enable, 0);
        fetch(0, 18'h06A19, 0, 1'b0, '0);
        // flush in HOLD with instr_ready: no accept, same address refetched
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("fl_hold_valid1", instr_valid, 1);
        instr_ready = 1'b1;
        branch_enable = 1'b1;
        flush = 1'b1;
        tick();
        instr_ready = 1'b0;
        branch_enable = 1'b0;
        flush = 1'b0;
        check("fl_hold_valid", instr_valid, 0);
        check("fl_hold_pcu", pc_update_enable, 0);
        fetch(0, 18'h12492, 0, 1'b0, '0);
        // reset mid-HOLD with instr_ready: no pulse
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("rh_valid1", instr_valid, 1);
        instr_ready = 1'b1;
        reset_n = 1'b0;
        tick();
        instr_ready = 1'b0;
        reset_n = 1'b1;
        check("rh_pcu", pc_update_enable, 0);
        check("rh_valid", instr_valid, 0);
        check("rh_addr", mem_addr, 12'hAAA);
        tick();
        check("rh_pcu_after", pc_update_enable, 0);
        check("rh_pc_unchanged", pc_int, exp_pc);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        fetch(0, 18'h20A05, 0, 1'b0, '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
